// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared combinational ALU: accept, execute, respond.
// Define ALU_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [5:0]        req0_opcode,
  input  logic [DATA_W-1:0] req0_rs,
  input  logic [DATA_W-1:0] req0_rt,
  input  logic [4:0]        req0_shamt,
  input  logic [5:0]        req0_funct,
  input  logic [15:0]       req0_imm,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [5:0]        req1_opcode,
  input  logic [DATA_W-1:0] req1_rs,
  input  logic [DATA_W-1:0] req1_rt,
  input  logic [4:0]        req1_shamt,
  input  logic [5:0]        req1_funct,
  input  logic [15:0]       req1_imm,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_branch,
  output logic [5:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_rs_content,
  output logic [DATA_W-1:0] alu_rt_content,
  output logic [4:0]        alu_shamt,
  output logic [5:0]        alu_control,
  output logic [15:0]       alu_immediate,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_sig_branch,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   grant;
  logic   grant_q;
  logic   take;
  logic   rsp_done;

`ifdef ALU_ARB_RR_EN
  logic last_grant;

  // On contention, favour whoever was not served last.
  always_comb begin
    grant = ~req0_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
  end
`else
  always_comb grant = ~req0_valid;
`endif

  assign rsp_done = (state == RESP) && (grant_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~grant;
          req1_ready = grant;
          take       = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (take) grant_q <= grant;
`ifdef ALU_ARB_RR_EN
      if (rsp_done) last_grant <= grant_q;
`endif
    end
  end

  // Stage boundary: granted request fields drive the ALU; result captured one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode     <= '0;
      alu_rs_content <= '0;
      alu_rt_content <= '0;
      alu_shamt      <= '0;
      alu_control    <= '0;
      alu_immediate  <= '0;
      rsp_result     <= '0;
      rsp_branch     <= 1'b0;
    end else begin
      if (take) begin
        alu_opcode     <= grant ? req1_opcode : req0_opcode;
        alu_rs_content <= grant ? req1_rs     : req0_rs;
        alu_rt_content <= grant ? req1_rt     : req0_rt;
        alu_shamt      <= grant ? req1_shamt  : req0_shamt;
        alu_control    <= grant ? req1_funct  : req0_funct;
        alu_immediate  <= grant ? req1_imm    : req0_imm;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_branch <= alu_sig_branch;
      end
    end
  end

  assign rsp0_valid = (state == RESP) && !grant_q;
  assign rsp1_valid = (state == RESP) &&  grant_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences, randomized scoreboard run.
// Honours ALU_ARB_RR_EN for the expected arbitration policy.
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLL = 6'b000000, OP_BEQ = 6'b000100;

  typedef struct {
    logic [5:0]        opcode;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
  } req_t;

  typedef struct {
    int                port;
    req_t              r;
    logic [DATA_W-1:0] res;
    logic              br;
  } vec_t;

  typedef struct {
    int          port;
    logic [32:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0] req0_opcode, req1_opcode, req0_funct, req1_funct;
  logic [DATA_W-1:0] req0_rs, req0_rt, req1_rs, req1_rt;
  logic [4:0] req0_shamt, req1_shamt;
  logic [15:0] req0_imm, req1_imm;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic rsp_branch;
  logic [5:0] alu_opcode, alu_control;
  logic [DATA_W-1:0] alu_rs_content, alu_rt_content, alu_result;
  logic [4:0] alu_shamt;
  logic [15:0] alu_immediate;
  logic alu_sig_branch, busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_rs(req0_rs), .req0_rt(req0_rt), .req0_shamt(req0_shamt),
    .req0_funct(req0_funct), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_rs(req1_rs), .req1_rt(req1_rt), .req1_shamt(req1_shamt),
    .req1_funct(req1_funct), .req1_imm(req1_imm),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_branch(rsp_branch),
    .alu_opcode(alu_opcode), .alu_rs_content(alu_rs_content),
    .alu_rt_content(alu_rt_content), .alu_shamt(alu_shamt),
    .alu_control(alu_control), .alu_immediate(alu_immediate),
    .alu_result(alu_result), .alu_sig_branch(alu_sig_branch), .busy(busy)
  );

  // Environment ALU: {branch, result}
  function automatic logic [32:0] alu_fn(input req_t r);
    logic [31:0] res;
    case (r.funct)
      F_ADD:   res = r.rs + r.rt;
      F_SUB:   res = r.rs - r.rt;
      F_AND:   res = r.rs & r.rt;
      F_OR:    res = r.rs | r.rt;
      F_SLL:   res = r.rt << r.shamt;
      default: res = r.rs + {{16{r.imm[15]}}, r.imm};
    endcase
    return {(r.opcode == OP_BEQ) && (r.rs == r.rt), res};
  endfunction

  always_comb begin
    req_t a;
    a.opcode = alu_opcode; a.rs = alu_rs_content; a.rt = alu_rt_content;
    a.shamt = alu_shamt; a.funct = alu_control; a.imm = alu_immediate;
    {alu_sig_branch, alu_result} = alu_fn(a);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic req_t mkr(input logic [5:0] op, input logic [5:0] fn,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [4:0] sh, input logic [15:0] imm);
    req_t r;
    r.opcode = op; r.funct = fn; r.rs = rs; r.rt = rt; r.shamt = sh; r.imm = imm;
    return r;
  endfunction

  function automatic vec_t mkv(input int p, input req_t r, input logic [31:0] res, input logic br);
    vec_t v;
    v.port = p; v.r = r; v.res = res; v.br = br;
    return v;
  endfunction

  task automatic drive_req(input int n, input logic v, input req_t r);
    if (n == 0) begin
      req0_valid = v; req0_opcode = r.opcode; req0_rs = r.rs; req0_rt = r.rt;
      req0_shamt = r.shamt; req0_funct = r.funct; req0_imm = r.imm;
    end else begin
      req1_valid = v; req1_opcode = r.opcode; req1_rs = r.rs; req1_rt = r.rt;
      req1_shamt = r.shamt; req1_funct = r.funct; req1_imm = r.imm;
    end
  endtask

  // Called at negedge+1; polls for a ready for a bounded number of cycles.
  task automatic wait_grant(output int g);
    for (int i = 0; i < 20; i++) begin
      if (req0_ready || req1_ready) begin
        if (req0_ready && req1_ready) check("ready_onehot", 2'b11, 2'b01);
        g = req1_ready ? 1 : 0;
        return;
      end
      @(negedge clk); #1;
    end
    g = -1;
    check("grant_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int g;
    drive_req(v.port, 1'b1, v.r);
    #1;
    wait_grant(g);
    check({tag, "_grant"}, g, v.port);
    @(posedge clk); @(negedge clk);
    drive_req(v.port, 1'b0, v.r);
    #1;
    check({tag, "_alu_rs"}, alu_rs_content, v.r.rs);
    check({tag, "_alu_ctl"}, {alu_opcode, alu_control, alu_shamt, alu_immediate},
          {v.r.opcode, v.r.funct, v.r.shamt, v.r.imm});
    check({tag, "_exec_state"}, {busy, rsp0_valid, rsp1_valid}, 3'b100);
    @(posedge clk); @(negedge clk); #1;
    check({tag, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, (v.port == 0) ? 2'b01 : 2'b10);
    check({tag, "_result"}, rsp_result, v.res);
    check({tag, "_branch"}, rsp_branch, v.br);
    if (v.port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check({tag, "_idle"}, busy, 0);
    @(negedge clk);
  endtask

  function automatic req_t rand_req();
    req_t r;
    logic [5:0] fs[6];
    fs[0] = F_ADD; fs[1] = F_SUB; fs[2] = F_AND; fs[3] = F_OR; fs[4] = F_SLL;
    fs[5] = 6'($urandom);
    r.funct  = fs[$urandom_range(0, 5)];
    r.opcode = ($urandom_range(0, 1) == 1) ? OP_BEQ : 6'($urandom);
    r.rs     = $urandom;
    r.rt     = ($urandom_range(0, 3) == 0) ? r.rs : $urandom;
    r.shamt  = 5'($urandom);
    r.imm    = 16'($urandom);
    return r;
  endfunction

  vec_t tbl[8];
  req_t zr;

  initial begin
    zr = mkr(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    drive_req(0, 1'b0, zr); drive_req(1, 1'b0, zr);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_ready", {req0_ready, req1_ready}, 0);
    check("reset_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    check("reset_alu", {alu_opcode, alu_rs_content, alu_rt_content, alu_shamt, alu_control, alu_immediate} == 0, 1);
    check("reset_rsp", {rsp_result, rsp_branch}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    tbl[0] = mkv(0, mkr(6'd0, F_SUB, 52, 4, 0, 0), 32'd48, 1'b0);
    tbl[1] = mkv(1, mkr(6'd0, F_SUB, 10, 20, 0, 0), 32'hFFFF_FFF6, 1'b0);
    tbl[2] = mkv(0, mkr(6'd0, F_ADD, 7, 8, 0, 0), 32'd15, 1'b0);
    tbl[3] = mkv(1, mkr(6'd0, F_AND, 32'hF0F0, 32'h0FF0, 0, 0), 32'h00F0, 1'b0);
    tbl[4] = mkv(0, mkr(6'd0, F_SLL, 0, 3, 5'd4, 0), 32'h30, 1'b0);
    tbl[5] = mkv(1, mkr(OP_BEQ, F_SUB, 9, 9, 0, 0), 32'd0, 1'b1);
    tbl[6] = mkv(0, mkr(6'b001000, 6'b111111, 100, 0, 0, 16'hFFFF), 32'd99, 1'b0);
    tbl[7] = mkv(1, mkr(OP_BEQ, F_OR, 32'hA0, 32'h05, 0, 0), 32'hA5, 1'b0);
    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Contention: both held valid for four operations, then req0 drops
    do_reset();
    begin
      int g;
      int exp_g[4];
`ifdef ALU_ARB_RR_EN
      exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
      exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`endif
      @(negedge clk);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      drive_req(0, 1'b1, mkr(0, F_SUB, 150, 25, 0, 0));
      drive_req(1, 1'b1, mkr(0, F_SUB, 74, 12, 0, 0));
      for (int k = 0; k < 5; k++) begin
        if (k == 4) req0_valid = 1'b0;
        #1;
        wait_grant(g);
        check($sformatf("cont%0d_grant", k), g, (k == 4) ? 1 : exp_g[k]);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk); #1;
        check($sformatf("cont%0d_rsp", k), {rsp1_valid, rsp0_valid}, (g == 1) ? 2'b10 : 2'b01);
        check($sformatf("cont%0d_res", k), rsp_result, (g == 1) ? 32'd62 : 32'd125);
        @(posedge clk); @(negedge clk);
      end
      req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    end

    // Backpressure on requester 0 while requester 1 waits
    begin
      int g;
      @(negedge clk);
      drive_req(0, 1'b1, mkr(0, F_SUB, 15, 15, 0, 0));
      #1;
      wait_grant(g);
      check("bp_grant", g, 0);
      @(posedge clk); @(negedge clk);
      req0_valid = 1'b0;
      drive_req(1, 1'b1, mkr(0, F_ADD, 1, 2, 0, 0));
      @(posedge clk);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk); #1;
        check($sformatf("bp%0d_valid", c), rsp0_valid, 1);
        check($sformatf("bp%0d_result", c), rsp_result, 0);
        check($sformatf("bp%0d_req1_ready", c), req1_ready, 0);
        check($sformatf("bp%0d_busy", c), busy, 1);
      end
      rsp0_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp0_ready = 1'b0;
      #1;
      wait_grant(g);
      check("bp_req1_grant", g, 1);
      @(posedge clk); @(negedge clk);
      req1_valid = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      check("bp_req1_rsp", {rsp1_valid, rsp0_valid}, 2'b10);
      check("bp_req1_res", rsp_result, 3);
      rsp1_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp1_ready = 1'b0;
    end

    // Asynchronous reset while a response is held
    begin
      int g;
      drive_req(0, 1'b1, mkr(0, F_ADD, 5, 6, 0, 0));
      #1;
      wait_grant(g);
      @(posedge clk); @(negedge clk);
      req0_valid = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      check("rr_pre_valid", rsp0_valid, 1);
      check("rr_pre_res", rsp_result, 11);
      #2 rst_n = 1'b0;
      #1;
      check("rr_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
      check("rr_busy", busy, 0);
      check("rr_result", rsp_result, 0);
      check("rr_alu_rs", alu_rs_content, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(tbl[0], "post_rst");
    end

    // Randomized run against a transaction-level scoreboard
    do_reset();
    begin
      exp_t q[$];
      logic v[2];
      req_t f[2];
      int issued[2];
      int target, completed, last, g, eg, p;
      target = 30; completed = 0; last = 1;
      v[0] = 1'b0; v[1] = 1'b0; issued[0] = 0; issued[1] = 0;
      f[0] = zr; f[1] = zr;
      for (int cyc = 0; cyc < 4000 && completed < 2 * target; cyc++) begin
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
          if (!v[n] && issued[n] < target && $urandom_range(0, 2) != 0) begin
            v[n] = 1'b1; f[n] = rand_req(); issued[n]++;
          end
          drive_req(n, v[n], f[n]);
        end
        rsp0_ready = ($urandom_range(0, 3) != 0);
        rsp1_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (req0_ready || req1_ready) begin
          check("rnd_ready_onehot", req0_ready && req1_ready, 0);
          check("rnd_ready_when_idle", q.size(), 0);
          g = req1_ready ? 1 : 0;
`ifdef ALU_ARB_RR_EN
          eg = (v[0] && v[1]) ? (1 - last) : (v[0] ? 0 : 1);
`else
          eg = v[0] ? 0 : 1;
`endif
          check("rnd_grant", g, eg);
          q.push_back('{port: g, exp: alu_fn(f[g])});
          v[g] = 1'b0;
        end else if (q.size() == 0 && (v[0] || v[1])) begin
          check("rnd_idle_stall", 0, 1);
        end
        if (rsp0_valid || rsp1_valid) begin
          check("rnd_rsp_onehot", rsp0_valid && rsp1_valid, 0);
          p = rsp1_valid ? 1 : 0;
          if (q.size() == 0) begin
            check("rnd_rsp_unexpected", 1, 0);
          end else begin
            check("rnd_rsp_port", p, q[0].port);
            check("rnd_rsp_data", {rsp_branch, rsp_result}, q[0].exp);
            if ((p == 0) ? rsp0_ready : rsp1_ready) begin
              void'(q.pop_front());
              last = p;
              completed++;
            end
          end
        end
      end
      check("rnd_completed", completed, 2 * target);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
